mul_special_pipe: RTL and testbench



---
 rtl/mul_pkg.sv | 24 ++
 rtl/mul_special_pipe_if.sv | 33 +++
 rtl/mul_fp_classify.sv | 27 ++
 rtl/mul_special_pipe.sv | 146 ++++++++++++++
 tb/tb_mul_special_pipe.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the FP multiplier datapath.
package mul_pkg;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } fp_class_t;

    // Widest mantissa the quiet-NaN helper can handle.
    localparam int unsigned MUL_MAX_MANT_W = 64;
    localparam int unsigned MUL_FLAG_W = 1;
    localparam int unsigned MUL_FLAG_INVALID = 0;

    // Quiets a NaN mantissa of width mant_w: forces its MSB, keeps the payload below it.
    function automatic logic [MUL_MAX_MANT_W-1:0] qnan_mant(
        input logic [MUL_MAX_MANT_W-1:0] mant,
        input int unsigned               mant_w
    );
        return mant | (MUL_MAX_MANT_W'(1) << (mant_w - 1));
    endfunction

endpackage

// File: rtl/mul_special_pipe_if.sv
// Operand/result handshake bundle for mul_special_pipe; master is the driver, slave the block.
interface mul_special_pipe_if #(
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned TAG_W  = 4
);
    localparam int unsigned W = 1 + EXPO_W + MANT_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             special;
    logic [W-1:0]     res;
    logic [TAG_W-1:0] out_tag;
    logic             out_invalid;
    logic             flag_clr;
    logic             flags;

    modport master (
        output in_valid, a, b, in_tag, out_ready, flag_clr,
        input  in_ready, out_valid, special, res, out_tag, out_invalid, flags
    );

    modport slave (
        input  in_valid, a, b, in_tag, out_ready, flag_clr,
        output in_ready, out_valid, special, res, out_tag, out_invalid, flags
    );

endinterface

// File: rtl/mul_fp_classify.sv
// Combinational operand classifier: zero, Inf, NaN, signalling NaN.
module mul_fp_classify
    import mul_pkg::*;
#(
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic [EXPO_W-1:0] expo_i,
    input  logic [MANT_W-1:0] mant_i,
    output fp_class_t         cls_o
);

    logic expo_ones;
    logic expo_zero;
    logic mant_zero;

    always_comb begin
        expo_ones  = &expo_i;
        expo_zero  = ~|expo_i;
        mant_zero  = ~|mant_i;
        cls_o.zero = expo_zero & mant_zero;
        cls_o.inf  = expo_ones & mant_zero;
        cls_o.nan  = expo_ones & ~mant_zero;
        cls_o.snan = expo_ones & ~mant_zero & ~mant_i[MANT_W-1];
    end

endmodule

// File: rtl/mul_special_pipe.sv
// Two-stage special-operand resolution for the FP multiplier with sticky invalid flag.
// Define MUL_SPECIAL_CANON_NAN_EN to replace every NaN result with the canonical quiet NaN.
module mul_special_pipe
    import mul_pkg::*;
#(
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned TAG_W  = 4
) (
    input logic              clk,
    input logic              rst_n,
    mul_special_pipe_if.slave io
);

    localparam int unsigned W = 1 + EXPO_W + MANT_W;
    localparam logic [EXPO_W-1:0] ExpoOnes = {EXPO_W{1'b1}};
    localparam logic [MANT_W-1:0] QuietMsb = {1'b1, {(MANT_W-1){1'b0}}};

    fp_class_t cls_a, cls_b;

    mul_fp_classify #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_a (
        .expo_i (io.a[W-2 -: EXPO_W]),
        .mant_i (io.a[MANT_W-1:0]),
        .cls_o  (cls_a)
    );

    mul_fp_classify #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_b (
        .expo_i (io.b[W-2 -: EXPO_W]),
        .mant_i (io.b[MANT_W-1:0]),
        .cls_o  (cls_b)
    );

    // S1: operand sign/mantissa plus classification.
    logic             s1_valid_q;
    logic             a_sign_q, b_sign_q;
    logic [MANT_W-1:0] a_mant_q, b_mant_q;
    logic [TAG_W-1:0] s1_tag_q;
    fp_class_t        cls_a_q, cls_b_q;

    // S2: resolved result.
    logic             s2_valid_q;
    logic [W-1:0]     res_q, res_d;
    logic             special_q, special_d;
    logic             invalid_q, invalid_d;
    logic [TAG_W-1:0] s2_tag_q;
    logic [MUL_FLAG_W-1:0] flags_q, flags_d;

    logic s2_ready, s1_ready, out_fire;
    logic [W-1:0] nan_a, nan_b, dflt_nan;
    logic sign_x;

    assign s2_ready = ~s2_valid_q | io.out_ready;
    assign s1_ready = ~s1_valid_q | s2_ready;
    assign out_fire = s2_valid_q & io.out_ready;
    assign sign_x   = a_sign_q ^ b_sign_q;

`ifdef MUL_SPECIAL_CANON_NAN_EN
    assign nan_a    = {1'b0, ExpoOnes, QuietMsb};
    assign nan_b    = {1'b0, ExpoOnes, QuietMsb};
    assign dflt_nan = {1'b0, ExpoOnes, QuietMsb};
`else
    assign nan_a    = {a_sign_q, ExpoOnes,
                       MANT_W'(qnan_mant(MUL_MAX_MANT_W'(a_mant_q), MANT_W))};
    assign nan_b    = {b_sign_q, ExpoOnes,
                       MANT_W'(qnan_mant(MUL_MAX_MANT_W'(b_mant_q), MANT_W))};
    assign dflt_nan = {1'b1, ExpoOnes, QuietMsb};
`endif

    always_comb begin
        res_d     = '0;
        special_d = 1'b1;
        invalid_d = cls_a_q.snan | cls_b_q.snan;
        if (cls_a_q.nan) begin
            res_d = nan_a;
        end else if (cls_b_q.nan) begin
            res_d = nan_b;
        end else if ((cls_a_q.zero & cls_b_q.inf) | (cls_a_q.inf & cls_b_q.zero)) begin
            res_d     = dflt_nan;
            invalid_d = 1'b1;
        end else if (cls_a_q.inf | cls_b_q.inf) begin
            res_d = {sign_x, ExpoOnes, {MANT_W{1'b0}}};
        end else if (cls_a_q.zero | cls_b_q.zero) begin
            res_d = {sign_x, {(W-1){1'b0}}};
        end else begin
            special_d = 1'b0;
        end
    end

    // Set beats clear when both happen together.
    always_comb begin
        flags_d = flags_q;
        if (io.flag_clr) flags_d[MUL_FLAG_INVALID] = 1'b0;
        if (out_fire & invalid_q) flags_d[MUL_FLAG_INVALID] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            a_mant_q   <= '0;
            b_mant_q   <= '0;
            s1_tag_q   <= '0;
            cls_a_q    <= '0;
            cls_b_q    <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            special_q  <= 1'b0;
            invalid_q  <= 1'b0;
            s2_tag_q   <= '0;
            flags_q    <= '0;
        end else begin
            flags_q <= flags_d;
            if (s1_ready) begin
                s1_valid_q <= io.in_valid;
                if (io.in_valid) begin
                    a_sign_q <= io.a[W-1];
                    b_sign_q <= io.b[W-1];
                    a_mant_q <= io.a[MANT_W-1:0];
                    b_mant_q <= io.b[MANT_W-1:0];
                    s1_tag_q <= io.in_tag;
                    cls_a_q  <= cls_a;
                    cls_b_q  <= cls_b;
                end
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q     <= res_d;
                    special_q <= special_d;
                    invalid_q <= invalid_d;
                    s2_tag_q  <= s1_tag_q;
                end
            end
        end
    end

    assign io.in_ready    = s1_ready;
    assign io.out_valid   = s2_valid_q;
    assign io.res         = res_q;
    assign io.special     = special_q;
    assign io.out_tag     = s2_tag_q;
    assign io.out_invalid = invalid_q;
    assign io.flags       = flags_q[MUL_FLAG_INVALID];

endmodule

// File: tb/tb_mul_special_pipe.sv
// Directed self-checking bench for mul_special_pipe (single precision defaults).
module tb_mul_special_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mul_special_pipe_if #(.EXPO_W(8), .MANT_W(23), .TAG_W(4)) bus ();

    mul_special_pipe #(.EXPO_W(8), .MANT_W(23), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Issue one op into an empty pipe, check its result, then let it handshake.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] eres,
                          input logic espec, input logic einv);
        int lat;
        bus.a        = a;
        bus.b        = b;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, 2);
        check({name, "_res"}, bus.res, eres);
        check({name, "_special"}, 32'(bus.special), 32'(espec));
        check({name, "_invalid"}, 32'(bus.out_invalid), 32'(einv));
        check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
        @(posedge clk); #1;
    endtask

    task automatic clear_flags();
        bus.flag_clr = 1'b1;
        @(posedge clk); #1;
        bus.flag_clr = 1'b0;
    endtask

    logic [31:0] exp_snan, exp_dflt, exp_qa, exp_qb;
    int          nxt, got, seen;
    logic        acc;

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.in_tag   = '0;
        bus.out_ready = 1'b1;
        bus.flag_clr = 1'b0;
`ifdef MUL_SPECIAL_CANON_NAN_EN
        exp_snan = 32'h7FC00000;
        exp_dflt = 32'h7FC00000;
        exp_qa   = 32'h7FC00000;
        exp_qb   = 32'h7FC00000;
`else
        exp_snan = 32'h7FE00000;
        exp_dflt = 32'hFFC00000;
        exp_qa   = 32'h7FC00001;
        exp_qb   = 32'hFFC00002;
`endif
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_res", bus.res, 0);
        check("rst_special", 32'(bus.special), 0);
        check("rst_out_tag", 32'(bus.out_tag), 0);
        check("rst_out_invalid", 32'(bus.out_invalid), 0);
        check("rst_flags", 32'(bus.flags), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);

        run_op("snan_a", 32'h7FA00000, 32'h3F800000, 4'h1, exp_snan, 1'b1, 1'b1);
        check("snan_flags_set", 32'(bus.flags), 1);
        clear_flags();
        check("flag_clr", 32'(bus.flags), 0);

        run_op("zero_x_inf", 32'h00000000, 32'hFF800000, 4'h2, exp_dflt, 1'b1, 1'b1);
        check("zero_x_inf_flags", 32'(bus.flags), 1);
        clear_flags();

        run_op("qnan_a", 32'h7FC00001, 32'hFFC00002, 4'h3, exp_qa, 1'b1, 1'b0);
        run_op("qnan_b", 32'h3F800000, 32'hFFC00002, 4'h4, exp_qb, 1'b1, 1'b0);
        check("qnan_no_flag", 32'(bus.flags), 0);
        run_op("inf_x_neg", 32'h7F800000, 32'hC0000000, 4'h5, 32'hFF800000, 1'b1, 1'b0);
        run_op("negzero", 32'h80000000, 32'h40000000, 4'h6, 32'h80000000, 1'b1, 1'b0);
        run_op("normal", 32'h3F800000, 32'h40000000, 4'h7, 32'h00000000, 1'b0, 1'b0);

        // Backpressure: stall output for four cycles while offering tags 1..4.
        bus.a         = 32'h3F800000;
        bus.b         = 32'h40000000;
        bus.out_ready = 1'b0;
        nxt = 1;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (cyc == 4) begin
                check("bp_accepted", 32'(nxt - 1), 2);
                check("bp_in_ready_low", 32'(bus.in_ready), 0);
                bus.out_ready = 1'b1;
            end
            bus.in_valid = (nxt <= 4);
            bus.in_tag   = 4'(nxt);
            #1;
            acc = bus.in_valid & bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                got++;
                check("bp_order", 32'(bus.out_tag), 32'(got));
            end
            @(posedge clk); #1;
            if (acc) nxt++;
        end
        bus.in_valid = 1'b0;
        check("bp_count", 32'(got), 4);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        check("bp_no_dup", 32'(seen), 0);

        // Clear and set in the same cycle: set wins.
        clear_flags();
        check("pre_same_flags", 32'(bus.flags), 0);
        bus.out_ready = 1'b0;
        bus.a        = 32'h7F800000;
        bus.b        = 32'h00000000;
        bus.in_tag   = 4'h9;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("same_out_valid", 32'(bus.out_valid), 1);
        check("same_invalid", 32'(bus.out_invalid), 1);
        bus.flag_clr  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.flag_clr = 1'b0;
        check("same_cycle_flags", 32'(bus.flags), 1);

        // Reset with two operations in flight.
        bus.out_ready = 1'b0;
        bus.a        = 32'h00000000;
        bus.b        = 32'h3F800000;
        bus.in_tag   = 4'hA;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_tag = 4'hB;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("inflight_valid", 32'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(bus.out_valid), 0);
        check("rst_mid_flags", 32'(bus.flags), 0);
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_in_ready", 32'(bus.in_ready), 1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        check("rst_discard", 32'(seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
